// File: rtl/conv_post_stage.sv
// conv_post_stage: captures the Pix accumulator results of the conv kernel loop,
// adds a bias, saturates to RES bits and optionally applies ReLU. Results are
// streamed out one per valid/ready handshake.
// Optional feature macro: CONV_POST_RELU_EN (defined -> negative results output as 0).
module conv_post_stage #(
    parameter int Pix = 3,
    parameter int RES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Pix-1:0][RES-1:0] acc_in_i,
    input  logic                    acc_done_i,
    input  logic [RES-1:0]          bias_i,
    output logic                    in_ready_o,
    output logic                    mac_clear_o,
    output logic [RES-1:0]          out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_last_o,
    output logic                    overrun_o
);

    localparam int IW = (Pix > 1) ? $clog2(Pix) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Bias add with saturation into the RES-bit signed range, then optional ReLU.
    function automatic logic [RES-1:0] proc_f(input logic [RES-1:0] x, input logic [RES-1:0] b);
        logic [RES:0]   sum;
        logic [RES-1:0] res;
        sum = {x[RES-1], x} + {b[RES-1], b};
        if (sum[RES] != sum[RES-1]) begin
            // Overflow: the extra sign bit tells the true direction.
            if (sum[RES]) begin
                res = {1'b1, {(RES-1){1'b0}}};
            end else begin
                res = {1'b0, {(RES-1){1'b1}}};
            end
        end else begin
            res = sum[RES-1:0];
        end
`ifdef CONV_POST_RELU_EN
        if (res[RES-1]) begin
            res = {RES{1'b0}};
        end else begin
            res = res;
        end
`endif
        return res;
    endfunction

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [RES-1:0] hold_q [Pix];
    logic [RES-1:0] bias_q;
    logic [RES-1:0] out_data_q, out_data_d;
    logic           out_valid_q;
    logic           out_last_q, out_last_d;
    logic           mac_clear_q;
    logic           overrun_q;

    logic           handshake_s;
    logic           last_s;
    logic           in_ready_s;
    logic           capture_s;
    logic           drop_s;
    logic           advance_s;
    logic [IW-1:0]  idx_inc_s;

    assign handshake_s = out_valid_q & out_ready_i;
    assign last_s      = (idx_q == IW'(Pix - 1));
    assign idx_inc_s   = idx_q + IW'(1);
    assign capture_s   = acc_done_i & in_ready_s;
    assign drop_s      = acc_done_i & ~in_ready_s;
    assign advance_s   = (state_q == ST_EMIT) & handshake_s & ~last_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a capture always (re)enters EMIT, the last handoff returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (capture_s) begin
                    state_d = ST_EMIT;
                end else if (handshake_s && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: capture is allowed when idle or while the last element hands off.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s = 1'b1;
            ST_EMIT: in_ready_s = handshake_s & last_s;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Next values of the element index and the registered output word.
    always_comb begin
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (capture_s) begin
            idx_d      = {IW{1'b0}};
            out_data_d = proc_f(acc_in_i[0], bias_i);
            out_last_d = (Pix == 1);
        end else if (advance_s) begin
            idx_d      = idx_inc_s;
            out_data_d = proc_f(hold_q[idx_inc_s], bias_q);
            out_last_d = (idx_inc_s == IW'(Pix - 1));
        end else if (handshake_s && last_s) begin
            idx_d      = {IW{1'b0}};
            out_data_d = out_data_q;
            out_last_d = 1'b0;
        end else begin
            idx_d      = idx_q;
            out_data_d = out_data_q;
            out_last_d = out_last_q;
        end
    end

    // Hold registers: loaded only on capture; dropped pulses leave them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < Pix; k++) begin
                hold_q[k] <= {RES{1'b0}};
            end
            bias_q <= {RES{1'b0}};
        end else if (capture_s) begin
            for (int k = 0; k < Pix; k++) begin
                hold_q[k] <= acc_in_i[k];
            end
            bias_q <= bias_i;
        end else begin
            for (int k = 0; k < Pix; k++) begin
                hold_q[k] <= hold_q[k];
            end
            bias_q <= bias_q;
        end
    end

    // Registered stream outputs, MAC clear pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= {IW{1'b0}};
            out_data_q  <= {RES{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            mac_clear_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= (state_d == ST_EMIT);
            out_last_q  <= out_last_d;
            mac_clear_q <= capture_s;
            overrun_q   <= overrun_q | drop_s;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign mac_clear_o = mac_clear_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_conv_post_stage.sv
// Randomized self-checking bench for conv_post_stage (Pix=3, RES=8) with a
// queue-based reference model of the result stream.
module tb_conv_post_stage;

    localparam int Pix = 3;
    localparam int RES = 8;

    logic                    clk;
    logic                    rst;
    logic [Pix-1:0][RES-1:0] acc_in;
    logic                    acc_done;
    logic [RES-1:0]          bias;
    logic                    in_ready;
    logic                    mac_clear;
    logic [RES-1:0]          out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    overrun;

    conv_post_stage #(.Pix(Pix), .RES(RES)) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_in_i    (acc_in),
        .acc_done_i  (acc_done),
        .bias_i      (bias),
        .in_ready_o  (in_ready),
        .mac_clear_o (mac_clear),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .overrun_o   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pending elements of the current burst.
    int   exp_q[$];
    bit   exp_ovr = 1'b0;
    bit   exp_mac = 1'b0;
    logic [RES-1:0] obs_data;
    bit   obs_valid;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Saturating bias add with optional ReLU, in plain integer arithmetic.
    function automatic int model_proc(input logic [RES-1:0] x, input logic [RES-1:0] b);
        int s;
        s = int'($signed(x)) + int'($signed(b));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef CONV_POST_RELU_EN
        if (s < 0) s = 0;
`endif
        return s & 255;
    endfunction

    // One clock cycle: drive inputs, compare all outputs, then advance the model.
    task automatic step(input bit r, input bit d, input logic [RES-1:0] a0, input logic [RES-1:0] a1,
                        input logic [RES-1:0] a2, input logic [RES-1:0] b, input bit rdy);
        bit exp_ir;
        bit hs;
        bit cap;
        @(negedge clk);
        rst       = r;
        acc_done  = d;
        acc_in[0] = a0;
        acc_in[1] = a1;
        acc_in[2] = a2;
        bias      = b;
        out_ready = rdy;
        #1;
        exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
        obs_data  = out_data;
        obs_valid = out_valid;
        check_val("out_valid", int'(out_valid), int'(exp_q.size() != 0));
        check_val("out_last", int'(out_last), int'(exp_q.size() == 1));
        check_val("in_ready", int'(in_ready), int'(exp_ir));
        check_val("mac_clear", int'(mac_clear), int'(exp_mac));
        check_val("overrun", int'(overrun), int'(exp_ovr));
        if (exp_q.size() != 0) begin
            check_val("out_data", int'(out_data), exp_q[0]);
        end
        if (r) begin
            exp_q.delete();
            exp_ovr = 1'b0;
            exp_mac = 1'b0;
        end else begin
            hs  = (exp_q.size() != 0) && rdy;
            cap = d && exp_ir;
            if (d && !exp_ir) exp_ovr = 1'b1;
            if (hs) void'(exp_q.pop_front());
            if (cap) begin
                exp_q.push_back(model_proc(a0, b));
                exp_q.push_back(model_proc(a1, b));
                exp_q.push_back(model_proc(a2, b));
            end
            exp_mac = cap;
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, rdy);
    endtask

    initial begin
        rst = 1'b1; acc_done = 1'b0; acc_in = '0; bias = 8'd0; out_ready = 1'b0;

        // Reset
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        idle(1'b1);
        check_val("rst_data", int'(obs_data), 0);

        // Basic burst
        step(1'b0, 1'b1, 8'd10, 8'd20, 8'd30, 8'd5, 1'b1);
        idle(1'b1); check_val("basic_e0", int'(obs_data), 15);
        idle(1'b1); check_val("basic_e1", int'(obs_data), 25);
        idle(1'b1); check_val("basic_e2", int'(obs_data), 35);
        idle(1'b1);

        // Saturation, positive and negative bias
        step(1'b0, 1'b1, 8'd120, 8'h80, 8'hFB, 8'd10, 1'b1);
        idle(1'b1); check_val("sat_p0", int'(obs_data), 127);
`ifdef CONV_POST_RELU_EN
        idle(1'b1); check_val("sat_p1", int'(obs_data), 0);
`else
        idle(1'b1); check_val("sat_p1", int'(obs_data), 138);
`endif
        idle(1'b1); check_val("sat_p2", int'(obs_data), 5);
        step(1'b0, 1'b1, 8'd120, 8'h80, 8'hFB, 8'hF6, 1'b1);
        idle(1'b1); check_val("sat_n0", int'(obs_data), 110);
`ifdef CONV_POST_RELU_EN
        idle(1'b1); check_val("sat_n1", int'(obs_data), 0);
        idle(1'b1); check_val("sat_n2", int'(obs_data), 0);
`else
        idle(1'b1); check_val("sat_n1", int'(obs_data), 128);
        idle(1'b1); check_val("sat_n2", int'(obs_data), 241);
`endif

        // Backpressure on element 1
        step(1'b0, 1'b1, 8'd1, 8'd2, 8'd3, 8'd0, 1'b1);
        idle(1'b1);
        idle(1'b0); check_val("bp_hold_a", int'(obs_data), 2);
        idle(1'b0); check_val("bp_hold_b", int'(obs_data), 2);
        idle(1'b1); check_val("bp_resume", int'(obs_data), 2);
        idle(1'b1); check_val("bp_e2", int'(obs_data), 3);

        // Back-to-back capture on the last handoff, then a dropped pulse
        step(1'b0, 1'b1, 8'd40, 8'd41, 8'd42, 8'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 1'b1, 8'd50, 8'd51, 8'd52, 8'd1, 1'b1);
        step(1'b0, 1'b1, 8'd99, 8'd99, 8'd99, 8'd0, 1'b0);
        check_val("b2b_e0", int'(obs_data), 51);
        check_val("b2b_valid", int'(obs_valid), 1);
        idle(1'b1); check_val("ovr_e0", int'(obs_data), 51);
        check_val("ovr_flag", int'(overrun), 1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Mid-burst reset
        step(1'b0, 1'b1, 8'd7, 8'd8, 8'd9, 8'd0, 1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        idle(1'b1);
        check_val("mr_valid", int'(obs_valid), 0);
        step(1'b0, 1'b1, 8'd60, 8'd61, 8'd62, 8'd0, 1'b1);
        idle(1'b1); check_val("mr_restart", int'(obs_data), 60);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
